fg_fd_sched: RTL and testbench
==============================

# fg_fd_sched

Flow descriptor consumer/scheduler for the flow generator. It pops one flow descriptor at a time from the descriptor FIFO's output port and splits the flow length into burst descriptors (dest, length, last). It paces those bursts with a fractional rate accumulator, so long-run throughput is rate_num/rate_denom bytes per clock. It sits between the descriptor FIFO and the packet/burst generator.

## Interface
Parameters:
- DEST_WIDTH, 8, width of flow destination field
- CREDIT_WIDTH, 32, width of byte-credit counter (saturating)

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous, active-high
- input_fd_valid  in  1  descriptor valid
- input_fd_ready  out  1  descriptor accepted when valid & ready
- input_fd_dest  in  DEST_WIDTH  destination
- input_fd_rate_num  in  16  rate numerator
- input_fd_rate_denom  in  16  rate denominator
- input_fd_len  in  32  flow length, bytes
- input_fd_burst_len  in  32  max burst length, bytes
- output_bd_valid  out  1  burst descriptor valid
- output_bd_ready  in  1  burst descriptor accepted when valid & ready
- output_bd_dest  out  DEST_WIDTH  destination of current flow
- output_bd_len  out  32  burst length, bytes
- output_bd_last  out  1  final burst of flow
- busy  out  1  state != IDLE or output_bd_valid
- bytes_remaining  out  32  flow bytes not yet issued

## Operation
- States: IDLE, ACTIVE, DRAIN.
- IDLE: input_fd_ready=1. On accept, latch dest/num/denom/burst_len, set remaining=len, acc=0, credit=0.
  - len=0: go to DRAIN without emitting any burst.
  - Otherwise: go to ACTIVE.
- Effective burst: eb = burst_len (eb = remaining if burst_len=0); cur = min(remaining, eb).
- Credit update, ACTIVE only, every cycle:
  - Full rate (denom=0 or num>=denom): inc=1.
  - Otherwise: s=acc+num (17 bit). If s>=denom: acc<=s-denom, inc=1; else acc<=s, inc=0.
  - credit saturates at all-ones.
- Issue condition (registered values): ACTIVE & credit>=cur & (~output_bd_valid | output_bd_ready).
- On issue:
  - Load output register: len=cur, dest, last=(remaining==cur).
  - Update credit<=credit+inc-cur and remaining<=remaining-cur.
  - If last: go to DRAIN.
- DRAIN: go to IDLE once output_bd_valid=0, or on the cycle output_bd_ready is high. Credit and acc are not carried into the next flow.
- Output register: output_bd_valid clears on ready & ~issue. Fields are stable while valid & ~ready.

## Timing
- Reset: state=IDLE, input_fd_ready=1 (combinational from IDLE), output_bd_valid=0, output_bd_len=0, output_bd_dest=0, output_bd_last=0, busy=0, bytes_remaining=0, acc=0, credit=0. Reset mid-flow discards the flow and any pending burst with no handshake.
- Accept at edge T: ACTIVE from T+1 with credit=0. First issue decision is the first ACTIVE cycle with credit>=cur; output_bd_valid rises on the following edge.
- Back-to-back issue is allowed when ready=1 and credit suffices. Issue never occurs while valid & ~ready.
- ACTIVE stalls under backpressure; credit keeps accumulating (bursting allowed up to saturation).
- IDLE re-entry: input_fd_ready is high the cycle after DRAIN exits. Minimum one idle cycle between flows.
- Wrap: remaining never underflows, since cur<=remaining.

## Structure
- Shared package fg_pkg holds the state encoding (IDLE/ACTIVE/DRAIN) and the LEN_WIDTH=32 and RATE_WIDTH=16 constants.
- One sub-module: fg_rate_acc.
  - Inputs: num, denom, clear, enable.
  - Outputs: inc, with 16-bit acc held internally.
- All remaining logic lives in fg_fd_sched.

## Test plan
- Rate 1/1, len=256, burst=64, ready=1: accept at T → bursts of 64 with valid at T+66, T+130, T+194, T+258; last=1 only on the 4th; then input_fd_ready=1.
- Rate 1/4, len=8, burst=4: two bursts of 4 spaced 16 cycles; last on the second; bytes_remaining 8→4→0.
- len=100, burst=64, rate 1/1: bursts 64 then 36 (last); burst=0 → single burst of 100 at T+102.
- len=0: accepted, no output_bd_valid; input_fd_ready returns high within 2 cycles.
- Backpressure: ready=0 for 200 cycles during a rate-1/1 flow (len=256, burst=64) → first burst held stable, then remaining bursts issue back-to-back once ready=1.
- Assert rst mid-flow with valid pending → next cycle valid=0, ready=1, bytes_remaining=0; a new descriptor then runs from credit 0.

Source files
------------

// File: rtl/fg_pkg.sv
// Shared definitions for the flow generator.
// Holds the scheduler state encoding and common field widths.
package fg_pkg;

    localparam int LEN_WIDTH  = 32;
    localparam int RATE_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } state_e;

endpackage

// File: rtl/fg_rate_acc.sv
// Fractional rate accumulator: inc pulses num times per denom enabled cycles.
// Ports: clk, rst, num, denom, clear, enable in; inc out.
module fg_rate_acc
    import fg_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [RATE_WIDTH-1:0] num,
    input  logic [RATE_WIDTH-1:0] denom,
    input  logic                  clear,
    input  logic                  enable,
    output logic                  inc
);

    logic [RATE_WIDTH-1:0] acc_q;
    logic [RATE_WIDTH-1:0] acc_d;
    logic [RATE_WIDTH:0]   sum;
    logic                  full;
    logic                  hit;

    always_comb begin
        full  = (denom == '0) || (num >= denom);
        sum   = {1'b0, acc_q} + {1'b0, num};
        hit   = sum >= {1'b0, denom};
        inc   = enable & (full | hit);
        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (enable && !full) begin
            // acc stays below denom, so the wrapped 16-bit result is exact
            if (hit) acc_d = acc_q + num - denom;
            else     acc_d = acc_q + num;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) acc_q <= '0;
        else     acc_q <= acc_d;
    end

endmodule

// File: rtl/fg_fd_sched.sv
// Flow descriptor scheduler: splits each flow into paced burst descriptors.
// Ports: input_fd_* descriptor in, output_bd_* burst out, busy/bytes_remaining status.
module fg_fd_sched
    import fg_pkg::*;
#(
    parameter int DEST_WIDTH   = 8,
    parameter int CREDIT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  input_fd_valid,
    output logic                  input_fd_ready,
    input  logic [DEST_WIDTH-1:0] input_fd_dest,
    input  logic [RATE_WIDTH-1:0] input_fd_rate_num,
    input  logic [RATE_WIDTH-1:0] input_fd_rate_denom,
    input  logic [LEN_WIDTH-1:0]  input_fd_len,
    input  logic [LEN_WIDTH-1:0]  input_fd_burst_len,
    output logic                  output_bd_valid,
    input  logic                  output_bd_ready,
    output logic [DEST_WIDTH-1:0] output_bd_dest,
    output logic [LEN_WIDTH-1:0]  output_bd_len,
    output logic                  output_bd_last,
    output logic                  busy,
    output logic [LEN_WIDTH-1:0]  bytes_remaining
);

    localparam int CMP_W =
        (CREDIT_WIDTH > LEN_WIDTH) ? CREDIT_WIDTH : LEN_WIDTH;

    state_e                  state_q, state_d;
    logic [DEST_WIDTH-1:0]   dest_q, dest_d;
    logic [RATE_WIDTH-1:0]   num_q, num_d;
    logic [RATE_WIDTH-1:0]   denom_q, denom_d;
    logic [LEN_WIDTH-1:0]    blen_q, blen_d;
    logic [LEN_WIDTH-1:0]    rem_q, rem_d;
    logic [CREDIT_WIDTH-1:0] credit_q, credit_d;
    logic                    ov_q, ov_d;
    logic [DEST_WIDTH-1:0]   odest_q, odest_d;
    logic [LEN_WIDTH-1:0]    olen_q, olen_d;
    logic                    olast_q, olast_d;

    logic [LEN_WIDTH-1:0] eb;
    logic [LEN_WIDTH-1:0] cur;
    logic                 is_last;
    logic                 enough;
    logic                 issue;
    logic                 inc;
    logic                 active;

    assign active = (state_q == ST_ACTIVE);

    fg_rate_acc u_rate (
        .clk    (clk),
        .rst    (rst),
        .num    (num_q),
        .denom  (denom_q),
        .clear  (!active),
        .enable (active),
        .inc    (inc)
    );

    always_comb begin
        eb      = (blen_q == '0) ? rem_q : blen_q;
        cur     = (rem_q < eb) ? rem_q : eb;
        is_last = (rem_q == cur);
        enough  = CMP_W'(credit_q) >= CMP_W'(cur);
        issue   = active && enough && (!ov_q || output_bd_ready);
    end

    always_comb begin
        state_d  = state_q;
        dest_d   = dest_q;
        num_d    = num_q;
        denom_d  = denom_q;
        blen_d   = blen_q;
        rem_d    = rem_q;
        credit_d = credit_q;
        ov_d     = ov_q;
        odest_d  = odest_q;
        olen_d   = olen_q;
        olast_d  = olast_q;

        unique case (state_q)
            ST_IDLE: begin
                if (input_fd_valid) begin
                    dest_d   = input_fd_dest;
                    num_d    = input_fd_rate_num;
                    denom_d  = input_fd_rate_denom;
                    blen_d   = input_fd_burst_len;
                    rem_d    = input_fd_len;
                    credit_d = '0;
                    state_d  = (input_fd_len == '0) ? ST_DRAIN : ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (issue) begin
                    // credit >= cur > 0, so this cannot wrap
                    credit_d = credit_q - CREDIT_WIDTH'(cur)
                             + CREDIT_WIDTH'(inc);
                    rem_d    = rem_q - cur;
                    if (is_last) state_d = ST_DRAIN;
                end else if (inc && !(&credit_q)) begin
                    credit_d = credit_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                credit_d = '0;
                if (!ov_q || output_bd_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (issue) begin
            ov_d    = 1'b1;
            olen_d  = cur;
            odest_d = dest_q;
            olast_d = is_last;
        end else if (output_bd_ready) begin
            ov_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            dest_q   <= '0;
            num_q    <= '0;
            denom_q  <= '0;
            blen_q   <= '0;
            rem_q    <= '0;
            credit_q <= '0;
            ov_q     <= 1'b0;
            odest_q  <= '0;
            olen_q   <= '0;
            olast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            dest_q   <= dest_d;
            num_q    <= num_d;
            denom_q  <= denom_d;
            blen_q   <= blen_d;
            rem_q    <= rem_d;
            credit_q <= credit_d;
            ov_q     <= ov_d;
            odest_q  <= odest_d;
            olen_q   <= olen_d;
            olast_q  <= olast_d;
        end
    end

    assign input_fd_ready  = (state_q == ST_IDLE);
    assign output_bd_valid = ov_q;
    assign output_bd_dest  = odest_q;
    assign output_bd_len   = olen_q;
    assign output_bd_last  = olast_q;
    assign busy            = (state_q != ST_IDLE) || ov_q;
    assign bytes_remaining = rem_q;

endmodule

// File: tb/tb_fg_fd_sched.sv
// Self-checking bench for fg_fd_sched.
// Directed timing cases plus random traffic against a floor-arithmetic model.
module tb_fg_fd_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        input_fd_valid;
    logic        input_fd_ready;
    logic [7:0]  input_fd_dest;
    logic [15:0] input_fd_rate_num;
    logic [15:0] input_fd_rate_denom;
    logic [31:0] input_fd_len;
    logic [31:0] input_fd_burst_len;
    logic        output_bd_valid;
    logic        output_bd_ready;
    logic [7:0]  output_bd_dest;
    logic [31:0] output_bd_len;
    logic        output_bd_last;
    logic        busy;
    logic [31:0] bytes_remaining;

    always #5 clk = ~clk;

    fg_fd_sched dut (
        .clk                 (clk),
        .rst                 (rst),
        .input_fd_valid      (input_fd_valid),
        .input_fd_ready      (input_fd_ready),
        .input_fd_dest       (input_fd_dest),
        .input_fd_rate_num   (input_fd_rate_num),
        .input_fd_rate_denom (input_fd_rate_denom),
        .input_fd_len        (input_fd_len),
        .input_fd_burst_len  (input_fd_burst_len),
        .output_bd_valid     (output_bd_valid),
        .output_bd_ready     (output_bd_ready),
        .output_bd_dest      (output_bd_dest),
        .output_bd_len       (output_bd_len),
        .output_bd_last      (output_bd_last),
        .busy                (busy),
        .bytes_remaining     (bytes_remaining)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: credit after k active cycles is k (full rate)
    // or floor(k*num/denom); bursts consume credit in order.
    int         m_st;
    longint     m_rem, m_blen, m_k, m_used;
    longint     m_num, m_den;
    logic [7:0] m_dest;
    bit         m_ov;
    longint     m_olen;
    logic [7:0] m_odest;
    bit         m_olast;

    function automatic longint m_credit();
        if (m_den == 0 || m_num >= m_den) return m_k - m_used;
        return (m_k * m_num) / m_den - m_used;
    endfunction

    always @(posedge clk) begin
        longint eb, cur;
        bit     iss;
        if (rst) begin
            m_st <= 0; m_rem <= 0; m_k <= 0; m_used <= 0;
            m_ov <= 0; m_olen <= 0; m_odest <= 0; m_olast <= 0;
        end else begin
            iss = 0;
            cur = 0;
            if (m_st == 1) begin
                eb  = (m_blen == 0) ? m_rem : m_blen;
                cur = (m_rem < eb) ? m_rem : eb;
                iss = (m_credit() >= cur) && (!m_ov || output_bd_ready);
            end
            if (iss) begin
                m_ov <= 1; m_olen <= cur;
                m_odest <= m_dest; m_olast <= (m_rem == cur);
            end else if (output_bd_ready) begin
                m_ov <= 0;
            end
            case (m_st)
                0: if (input_fd_valid) begin
                    m_dest <= input_fd_dest;
                    m_num  <= longint'(input_fd_rate_num);
                    m_den  <= longint'(input_fd_rate_denom);
                    m_blen <= longint'(input_fd_burst_len);
                    m_rem  <= longint'(input_fd_len);
                    m_k    <= 0;
                    m_used <= 0;
                    m_st   <= (input_fd_len == 0) ? 2 : 1;
                end
                1: begin
                    m_k <= m_k + 1;
                    if (iss) begin
                        m_used <= m_used + cur;
                        m_rem  <= m_rem - cur;
                        if (m_rem == cur) m_st <= 2;
                    end
                end
                default: if (!m_ov || output_bd_ready) m_st <= 0;
            endcase
        end
    end

    int         cyc_n = 0;
    bit         pv = 0;
    longint     plen;
    bit         plast;
    int         rise_t[$];
    longint     rise_rem[$];
    int         hs_t[$];
    longint     hs_len[$];
    bit         hs_last[$];

    task automatic cyc();
        @(negedge clk);
        cyc_n++;
        if (pv && output_bd_ready && !rst) begin
            hs_t.push_back(cyc_n);
            hs_len.push_back(plen);
            hs_last.push_back(plast);
        end
        if (output_bd_valid && !pv) begin
            rise_t.push_back(cyc_n);
            rise_rem.push_back(longint'(bytes_remaining));
        end
        chk("fd_ready", input_fd_ready, m_st == 0);
        chk("bd_valid", output_bd_valid, m_ov);
        chk("bd_len", output_bd_len, m_olen);
        chk("bd_dest", output_bd_dest, m_odest);
        chk("bd_last", output_bd_last, m_olast);
        chk("busy", busy, (m_st != 0) || m_ov);
        chk("bytes_rem", bytes_remaining, m_rem);
        pv    = output_bd_valid;
        plen  = longint'(output_bd_len);
        plast = output_bd_last;
    endtask

    task automatic clr_q();
        rise_t.delete(); rise_rem.delete();
        hs_t.delete(); hs_len.delete(); hs_last.delete();
    endtask

    task automatic run_fd(input logic [7:0] d, input int num,
                          input int den, input int len,
                          input int blen, output int t0);
        for (int i = 0; i < 5000 && !input_fd_ready; i++) cyc();
        chk("wait_ready", input_fd_ready, 1'b1);
        input_fd_valid      = 1'b1;
        input_fd_dest       = d;
        input_fd_rate_num   = 16'(num);
        input_fd_rate_denom = 16'(den);
        input_fd_len        = 32'(len);
        input_fd_burst_len  = 32'(blen);
        t0 = cyc_n;
        cyc();
        input_fd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && (busy || !input_fd_ready); i++)
            cyc();
        chk("idle_timeout", busy, 1'b0);
    endtask

    int t0;
    int k;

    initial begin
        rst = 1'b1;
        input_fd_valid = 0; input_fd_dest = 0;
        input_fd_rate_num = 0; input_fd_rate_denom = 0;
        input_fd_len = 0; input_fd_burst_len = 0;
        output_bd_ready = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        cyc();
        chk("rst_valid", output_bd_valid, 1'b0);
        chk("rst_ready", input_fd_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);

        // rate 1/1, 256 in bursts of 64
        clr_q();
        run_fd(8'h5a, 1, 1, 256, 64, t0);
        wait_idle(1000);
        chk("t1_nrise", rise_t.size(), 4);
        for (int i = 0; i < 4 && i < rise_t.size(); i++)
            chk("t1_rise", rise_t[i] - t0, 66 + 64 * i);
        chk("t1_nhs", hs_t.size(), 4);
        for (int i = 0; i < 4 && i < hs_t.size(); i++) begin
            chk("t1_len", hs_len[i], 64);
            chk("t1_last", hs_last[i], i == 3);
        end

        // rate 1/4, 8 bytes in bursts of 4
        clr_q();
        run_fd(8'h11, 1, 4, 8, 4, t0);
        wait_idle(1000);
        chk("t2_nrise", rise_t.size(), 2);
        if (rise_t.size() == 2) begin
            chk("t2_first", rise_t[0] - t0, 18);
            chk("t2_gap", rise_t[1] - rise_t[0], 16);
            chk("t2_rem0", rise_rem[0], 4);
            chk("t2_rem1", rise_rem[1], 0);
        end
        if (hs_last.size() == 2) begin
            chk("t2_last0", hs_last[0], 1'b0);
            chk("t2_last1", hs_last[1], 1'b1);
        end

        // 100 bytes, burst 64 then burst 0
        clr_q();
        run_fd(8'h22, 1, 1, 100, 64, t0);
        wait_idle(1000);
        chk("t3_nhs", hs_len.size(), 2);
        if (hs_len.size() == 2) begin
            chk("t3_len0", hs_len[0], 64);
            chk("t3_len1", hs_len[1], 36);
            chk("t3_last1", hs_last[1], 1'b1);
        end
        clr_q();
        run_fd(8'h33, 1, 1, 100, 0, t0);
        wait_idle(1000);
        chk("t3b_nrise", rise_t.size(), 1);
        if (rise_t.size() == 1) chk("t3b_rise", rise_t[0] - t0, 102);
        if (hs_len.size() == 1) chk("t3b_len", hs_len[0], 100);

        // zero-length flow
        clr_q();
        run_fd(8'h44, 1, 1, 0, 16, t0);
        k = 1;
        while (!input_fd_ready && k < 10) begin cyc(); k++; end
        chk("t4_ready_lat", k, 2);
        for (int i = 0; i < 4; i++) cyc();
        chk("t4_nrise", rise_t.size(), 0);

        // backpressure
        clr_q();
        output_bd_ready = 1'b0;
        run_fd(8'h55, 1, 1, 256, 64, t0);
        while (rise_t.size() == 0 && cyc_n - t0 < 200) cyc();
        for (int i = 0; i < 200; i++) cyc();
        chk("t5_held", output_bd_valid, 1'b1);
        chk("t5_hlen", output_bd_len, 64);
        output_bd_ready = 1'b1;
        wait_idle(1000);
        chk("t5_nhs", hs_t.size(), 4);
        if (hs_t.size() == 4) begin
            chk("t5_b2b1", hs_t[1] - hs_t[0], 1);
            chk("t5_b2b2", hs_t[2] - hs_t[1], 1);
            chk("t5_last", hs_last[3], 1'b1);
        end

        // reset mid-flow with a pending burst
        output_bd_ready = 1'b0;
        run_fd(8'h66, 1, 1, 256, 64, t0);
        while (!output_bd_valid && cyc_n - t0 < 200) cyc();
        chk("t6_pend", output_bd_valid, 1'b1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("t6_valid", output_bd_valid, 1'b0);
        chk("t6_ready", input_fd_ready, 1'b1);
        chk("t6_rem", bytes_remaining, 0);
        output_bd_ready = 1'b1;
        cyc();
        clr_q();
        run_fd(8'h77, 1, 1, 64, 64, t0);
        wait_idle(1000);
        chk("t6_nrise", rise_t.size(), 1);
        if (rise_t.size() == 1) chk("t6_rise", rise_t[0] - t0, 66);

        // random traffic
        for (int i = 0; i < 12000; i++) begin
            output_bd_ready = ($urandom_range(0, 9) < 7);
            rst = ($urandom_range(0, 1499) == 0);
            input_fd_valid = ($urandom_range(0, 3) == 0);
            input_fd_dest = 8'($urandom);
            input_fd_rate_denom = 16'($urandom_range(0, 6));
            input_fd_rate_num = 16'($urandom_range(1, 7));
            input_fd_len = ($urandom_range(0, 7) == 0) ? 32'd0
                         : 32'($urandom_range(1, 120));
            input_fd_burst_len = 32'($urandom_range(0, 80));
            cyc();
        end
        rst = 1'b0;
        input_fd_valid = 1'b0;
        output_bd_ready = 1'b1;
        wait_idle(3000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
